// File: rtl/fifo_umbral.sv
// fifo_umbral: single-clock 8-entry FIFO with loadable almost-full/almost-empty
// thresholds and a sticky overflow/underflow error flag, one instance per lane.
// Latency: a word written on one edge can be popped from the next edge on; data_out
// is registered and valid one clock after the accepted pop (data_valid marks it).
// Backpressure: none. A push when full without a same-cycle pop is dropped, and a
// pop when empty is ignored. Both cases latch fifo_error until reset.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cfg_load              capture th_almost_full / th_almost_empty at this edge
//   push, data_in         write request and write data
//   pop                   read request
//   data_out, data_valid  registered read data, high for one cycle after a pop
//   fifo_empty/full       count == 0 / count == DEPTH
//   almost_full/empty     count >= full threshold / count <= empty threshold
//   fifo_error            sticky overflow/underflow indication
//   count                 occupancy, 0..DEPTH
module fifo_umbral #(
  parameter int DATA_W       = 6,
  parameter int ADDR_W       = 3,
  parameter int TH_FULL_DEF  = 6,
  parameter int TH_EMPTY_DEF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [ADDR_W:0]   th_almost_full,
  input  logic [ADDR_W:0]   th_almost_empty,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [ADDR_W:0]   count
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0] TH_F_RST  = TH_FULL_DEF[ADDR_W:0];
  localparam logic [ADDR_W:0] TH_E_RST  = TH_EMPTY_DEF[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   th_full_reg;
  logic [ADDR_W:0]   th_empty_reg;

  logic pop_ok;
  logic push_ok;
  logic bad_op;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same
  // cycle. The reverse does not apply: a pop on empty never falls through to the
  // word being pushed.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != DEPTH_C) || pop_ok);
    bad_op  = (push && !push_ok) || (pop && !pop_ok);
  end

  // Flags come straight from registered state, so they move with count.
  always_comb begin
    fifo_empty   = (count == '0);
    fifo_full    = (count == DEPTH_C);
    almost_full  = (count >= th_full_reg);
    almost_empty = (count <= th_empty_reg);
  end

  // Storage is never cleared; reset only discards it by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      fifo_error   <= 1'b0;
      th_full_reg  <= TH_F_RST;
      th_empty_reg <= TH_E_RST;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_ONE;
      end
      if (bad_op) begin
        fifo_error <= 1'b1;
      end
      if (cfg_load) begin
        th_full_reg  <= th_almost_full;
        th_empty_reg <= th_almost_empty;
      end
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: scoreboard bench for fifo_umbral.
// Every cycle drives one set of inputs, advances a reference model, and compares
// every output against it. Pushed words queue up and are popped on reads.
module tb_fifo_umbral;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_load;
  logic [ADDR_W:0]   th_almost_full;
  logic [ADDR_W:0]   th_almost_empty;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic              fifo_error;
  logic [ADDR_W:0]   count;

  fifo_umbral #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TH_FULL_DEF(6), .TH_EMPTY_DEF(1)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .th_almost_full(th_almost_full), .th_almost_empty(th_almost_empty),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .data_valid(data_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic [DATA_W-1:0] sb [$];
  int                m_count;
  int                m_thf;
  int                m_the;
  bit                m_err;
  bit                m_vld;
  int                m_dout;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    check("count",        int'(count),        m_count);
    check("fifo_empty",   int'(fifo_empty),   int'(m_count == 0));
    check("fifo_full",    int'(fifo_full),    int'(m_count == DEPTH));
    check("almost_full",  int'(almost_full),  int'(m_count >= m_thf));
    check("almost_empty", int'(almost_empty), int'(m_count <= m_the));
    check("fifo_error",   int'(fifo_error),   int'(m_err));
    check("data_valid",   int'(data_valid),   int'(m_vld));
    check("data_out",     int'(data_out),     m_dout);
  endtask

  // One clock: drive inputs away from the edge, update the model at the edge,
  // sample outputs just after it.
  task automatic step(input bit rst, input bit ps, input int din, input bit pp,
                      input bit cfg = 1'b0, input int thf = 0, input int the = 0);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    reset           = rst;
    push            = ps;
    data_in         = DATA_W'(din);
    pop             = pp;
    cfg_load        = cfg;
    th_almost_full  = (ADDR_W+1)'(thf);
    th_almost_empty = (ADDR_W+1)'(the);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_count = 0; m_err = 1'b0; m_vld = 1'b0; m_dout = 0;
      m_thf = 6; m_the = 1;
    end else begin
      pop_ok  = pp && (m_count > 0);
      push_ok = ps && ((m_count < DEPTH) || pop_ok);
      if ((ps && !push_ok) || (pp && !pop_ok)) m_err = 1'b1;
      m_vld = pop_ok;
      if (pop_ok) m_dout = int'(sb.pop_front());
      if (push_ok) sb.push_back(DATA_W'(din));
      m_count = sb.size();
      if (cfg) begin
        m_thf = thf; m_the = the;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; cfg_load = 1'b0;
    data_in = '0; th_almost_full = '0; th_almost_empty = '0;
    m_count = 0; m_thf = 6; m_the = 1; m_err = 1'b0; m_vld = 1'b0; m_dout = 0;

    // Reset then idle
    step(1, 0, 0, 0);
    step(1, 1, 5, 1);
    repeat (3) step(0, 0, 0, 0);

    // Fill 1..8 in order, drain with wrap
    for (int i = 1; i <= 8; i++) step(0, 1, i, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("no_err_after_drain", int'(fifo_error), 0);

    // Overflow, then push+pop at full
    for (int i = 0; i < 8; i++) step(0, 1, 16 + i, 0);
    step(0, 1, 'h3F, 0);
    check("overflow_err", int'(fifo_error), 1);
    step(0, 1, 'h15, 1);
    check("full_pp_oldest", int'(data_out), 16);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Underflow, then push+pop on empty (no fall-through)
    step(0, 0, 0, 1);
    check("underflow_vld", int'(data_valid), 0);
    step(1, 0, 0, 0);
    step(0, 1, 'h2A, 1);
    check("empty_pp_count", int'(count), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("empty_pp_word", int'(data_out), 'h2A);
    step(1, 0, 0, 0);

    // Loaded thresholds 3/0, then 9 (almost_full never)
    step(0, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 40 + i, 0);
    check("af_at_th3", int'(almost_full), 1);
    step(0, 0, 0, 0, 1, 9, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 50 + i, 0);
    check("af_th9_full", int'(almost_full), 0);
    step(0, 0, 0, 0, 1, 0, 8);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);

    // Reset mid-operation with push and pop high
    for (int i = 0; i < 5; i++) step(0, 1, 7 + i, 0);
    step(1, 1, 33, 1);
    check("rst_mid_count", int'(count), 0);
    for (int i = 0; i < 6; i++) step(0, 1, 60 + i, 0);
    check("rst_th_default", int'(almost_full), 1);
    step(1, 0, 0, 0);

    // Random traffic with occasional threshold loads
    for (int i = 0; i < 400; i++) begin
      bit c = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 63),
           1'($urandom_range(0, 1)), c, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
